// File: rtl/integrate_dump_iq_if.sv
// Sample/dump bus for the integrate-and-dump accumulator.
// The master drives the samples, slave is the accumulator.
interface integrate_dump_iq_if #(
  parameter int unsigned NCH   = 3,
  parameter int unsigned IN_W  = 16,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned CNT_W = 16
) ();
  logic                   in_valid;
  logic [NCH*IN_W-1:0]    in_i;
  logic [NCH*IN_W-1:0]    in_q;
  logic [CNT_W-1:0]       period_len;
  logic                   sync;
  logic                   out_valid;
  logic                   out_ready;
  logic [NCH*ACC_W-1:0]   out_i;
  logic [NCH*ACC_W-1:0]   out_q;
  logic [CNT_W-1:0]       out_cnt;
  logic                   overrun;
  logic                   clr_ovr;

  modport master (
    output in_valid, in_i, in_q, period_len, sync, out_ready, clr_ovr,
    input  out_valid, out_i, out_q, out_cnt, overrun
  );

  modport slave (
    input  in_valid, in_i, in_q, period_len, sync, out_ready, clr_ovr,
    output out_valid, out_i, out_q, out_cnt, overrun
  );
endinterface

// File: rtl/integrate_dump_iq.sv
// Multi-channel I/Q integrate-and-dump with epoch sync, held dump register and overrun flag.
// Define SAT_EN for saturating (sticky-at-rail) accumulation; default build wraps.
module integrate_dump_iq #(
  parameter int unsigned NCH   = 3,
  parameter int unsigned IN_W  = 16,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned CNT_W = 16
) (
  input logic                clk,
  input logic                rst,
  integrate_dump_iq_if.slave bus_io
);
  // Lanes 0..NCH-1 are the I accumulators, NCH..2*NCH-1 the Q accumulators.
  localparam int unsigned NL = 2 * NCH;

  logic [IN_W-1:0]  samp   [NL];
  logic [ACC_W-1:0] base   [NL];
  logic [ACC_W-1:0] sum    [NL];
  logic [ACC_W-1:0] acc_q  [NL];
  logic [ACC_W-1:0] acc_d  [NL];
  logic [ACC_W-1:0] dump_q [NL];
  logic [ACC_W-1:0] dump_d [NL];

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic [CNT_W-1:0] per_q, per_d, per_map, eff;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  logic             last;

`ifdef SAT_EN
  logic [NL-1:0]    sat_q, sat_d;
  logic [ACC_W-1:0] raw [NL];
  logic [NL-1:0]    ovf;
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    assign samp[k]       = bus_io.in_i[k*IN_W +: IN_W];
    assign samp[NCH + k] = bus_io.in_q[k*IN_W +: IN_W];
    assign bus_io.out_i[k*ACC_W +: ACC_W] = dump_q[k];
    assign bus_io.out_q[k*ACC_W +: ACC_W] = dump_q[NCH + k];
  end

  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_cnt   = out_cnt_q;
  assign bus_io.overrun   = overrun_q;

  always_comb begin
    // Sync makes this cycle behave as the first sample slot of a fresh period.
    cnt_base = bus_io.sync ? '0 : cnt_q;
    per_map  = (bus_io.period_len == '0) ? CNT_W'(1) : bus_io.period_len;
    eff      = (cnt_base == '0) ? per_map : per_q;
    last     = bus_io.in_valid && (cnt_base == eff - CNT_W'(1));

    per_d = (bus_io.in_valid && cnt_base == '0) ? per_map : per_q;
    cnt_d = cnt_base;
    if (bus_io.in_valid) cnt_d = last ? '0 : cnt_base + CNT_W'(1);

`ifdef SAT_EN
    sat_d = '0;
`endif
    for (int l = 0; l < NL; l++) begin
      base[l] = bus_io.sync ? '0 : acc_q[l];
`ifdef SAT_EN
      raw[l] = base[l] + {{(ACC_W-IN_W){samp[l][IN_W-1]}}, samp[l]};
      ovf[l] = (base[l][ACC_W-1] == samp[l][IN_W-1]) && (raw[l][ACC_W-1] != base[l][ACC_W-1]);
      if (!bus_io.sync && sat_q[l]) begin
        sum[l] = base[l];
      end else if (ovf[l]) begin
        sum[l] = base[l][ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        sum[l] = raw[l];
      end
      if (bus_io.in_valid) begin
        sat_d[l] = !last && (ovf[l] || (!bus_io.sync && sat_q[l]));
      end else begin
        sat_d[l] = !bus_io.sync && sat_q[l];
      end
`else
      sum[l] = base[l] + {{(ACC_W-IN_W){samp[l][IN_W-1]}}, samp[l]};
`endif
      if (!bus_io.in_valid) acc_d[l] = base[l];
      else if (last)        acc_d[l] = '0;
      else                  acc_d[l] = sum[l];
      dump_d[l] = last ? sum[l] : dump_q[l];
    end

    out_cnt_d = last ? eff : out_cnt_q;
    if (last)                                   out_valid_d = 1'b1;
    else if (out_valid_q && bus_io.out_ready)   out_valid_d = 1'b0;
    else                                        out_valid_d = out_valid_q;

    // A dump landing on an unaccepted result overwrites it; set beats clear.
    if (last && out_valid_q && !bus_io.out_ready) overrun_d = 1'b1;
    else if (bus_io.clr_ovr)                      overrun_d = 1'b0;
    else                                          overrun_d = overrun_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < NL; l++) begin
        acc_q[l]  <= '0;
        dump_q[l] <= '0;
      end
      cnt_q       <= '0;
      per_q       <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SAT_EN
      sat_q       <= '0;
`endif
    end else begin
      for (int l = 0; l < NL; l++) begin
        acc_q[l]  <= acc_d[l];
        dump_q[l] <= dump_d[l];
      end
      cnt_q       <= cnt_d;
      per_q       <= per_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
`ifdef SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end
endmodule

// File: doc/integrate_dump_iq.md
Name: integrate_dump_iq

Overview:
Multi-channel I/Q integrate-and-dump accumulator for the GPS correlator back end, e.g. early/prompt/late taps. Each channel sums its I and Q samples over a runtime-programmable number of valid samples, typically one code period. At the end of the period it dumps the totals into a held output register with a valid/ready handshake. A sync strobe realigns the integration window to the code epoch, and an overrun flag reports dumps lost to backpressure.

Parameters:
NCH, 3, number of channels (I/Q pairs)
IN_W, 16, signed input sample width
ACC_W, 32, signed accumulator/output width; must be >= IN_W + ceil(log2(max period)) for lossless sums
CNT_W, 16, width of period_len and sample counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input samples valid this cycle
in_i  in  NCH*IN_W  signed I samples, channel k at bits [k*IN_W +: IN_W]
in_q  in  NCH*IN_W  signed Q samples, same packing
period_len  in  CNT_W  samples per integration period (0 treated as 1)
sync  in  1  single-cycle epoch strobe; restarts the period, discarding the partial sum
out_valid  out  1  dump result held and valid
out_ready  in  1  consumer accepts the result
out_i  out  NCH*ACC_W  signed I sums, same packing
out_q  out  NCH*ACC_W  signed Q sums
out_cnt  out  CNT_W  number of samples in the held dump
overrun  out  1  sticky: an unaccepted dump was overwritten
clr_ovr  in  1  clears overrun

Behaviour:
- Reset, asynchronous: all accumulators, the counter, the latched period, out_i, out_q, out_cnt, out_valid and overrun go to 0 immediately. Reset mid-period discards all partial and held data.
- Period latch: when cnt==0 and in_valid, period_len is captured into per_r, with 0 mapped to 1. Changes to period_len mid-period take effect at the next period.
- Effective length: eff = period_len (mapped) when cnt==0, else per_r.
- Accumulate: on in_valid, each acc += sign-extended sample, and cnt += 1. No change when in_valid=0.
- Dump: when in_valid and cnt == eff-1:
  - Output register loads acc+sample for every channel, and out_cnt = eff.
  - acc and cnt are cleared.
  - out_valid asserts the cycle after the final sample (latency 1).
- Handshake:
  - out_valid stays high with stable data until out_valid && out_ready, then drops the next cycle unless a new dump loads that same cycle.
  - A new dump with out_valid=1 and out_ready=1: loads the new data, out_valid stays 1, no overrun.
  - A new dump with out_valid=1 and out_ready=0: new data overwrites the held data, and overrun sets.
- Sync has priority over accumulate and dump:
  - acc and cnt clear, and no dump is produced for the partial period.
  - If in_valid is also high, that sample becomes sample 1 of the new period: acc = sample, cnt = 1, period_len latched.
  - If sync lands on what would be the dump sample, the dump is suppressed.
- overrun: set as above and cleared by clr_ovr. Set wins if both occur in the same cycle.
- Arithmetic: two's complement. Without SAT_EN, sums wrap modulo 2^ACC_W.

Optional Feature:
SAT_EN:
- Defined: each accumulator add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and sticks at the rail until dumped. The dump output (acc+sample) uses the same saturating add.
- Undefined: wrapping adds only, with no extra logic.

Test Plan:
1. NCH=3, period_len=4, ch0 I=1,2,3,4, Q=-1 each, out_ready=1 -> out_valid 1 cycle after 4th sample, out_i[ch0]=10, out_q[ch0]=-4, out_cnt=4, then out_valid=0.
2. period_len=10000, I=32767 every cycle, in_valid gapped 50% -> one dump with I=327670000, Q matches stimulus; the gaps do not count toward the period.
3. period_len=8, sync after 3 samples (I=5 each), sync coincident with I=7, then 7 more samples of I=1 -> no dump for the partial period; first dump I=14, out_cnt=8.
4. period_len=2, out_ready=0 across two dumps (I sums 3 then 11) -> overrun=1, out_i=11. Raise out_ready -> accepted, out_valid drops. Pulse clr_ovr -> overrun=0.
5. ACC_W=20, period_len=64, I=32767: with SAT_EN -> 524287; without SAT_EN -> -64 (wrapped).
6. Assert rst asynchronously mid-period with out_valid=1 -> outputs 0 before the next clk edge. After release, period_len=4, I=1 -> dump I=4.
